// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer.
//   state_e  : sequencer FSM state encoding (2 bits)
//   DATA_W   : operand / result width
//   STEP_MAX : largest amount the shift datapath applies in one cycle
//   STEP_W   : width of the per-cycle shift amount
package shift_pkg;

   localparam int DATA_W   = 8;
   localparam int STEP_MAX = 7;
   localparam int STEP_W   = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/shift.sv
// Combinational logical shifter with zero fill.
//   a : operand
//   d : direction, 0 = left, 1 = right
//   n : shift amount (0..7)
//   x : shifted result
module shift (
   input  logic [7:0] a,
   input  logic       d,
   input  logic [2:0] n,
   output logic [7:0] x
);

   assign x = d ? (a >> n) : (a << n);

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: applies a total shift of up to 2^AMT_W-1
// positions using a 0..7 shift datapath, one step per RUN cycle.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  / in_ready  : request handshake (in_data, in_dir, in_amt)
//   out_valid / out_ready : result handshake (out_data)
//   busy      : high whenever the FSM is not in IDLE
//
// state   | meaning
// --------+-------------------------------------------------------
// ST_IDLE | waiting for a request, in_ready high
// ST_RUN  | shifting by min(rem_q, 7) per cycle, rem_q counts down
// ST_DONE | result held on out_data until out_ready
module shift_seq
   import shift_pkg::*;
#(
   parameter int AMT_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_dir,
   input  logic [AMT_W-1:0]  in_amt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy
);

   localparam logic [AMT_W-1:0] STEP_MAX_AMT = AMT_W'(STEP_MAX);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                dir_q, dir_d;
   logic [AMT_W-1:0]    rem_q, rem_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic                busy_q, busy_d;

   logic [STEP_W-1:0]   step;
   logic [AMT_W-1:0]    step_ext;
   logic [DATA_W-1:0]   shifted;

   always_comb begin
      step     = (rem_q > STEP_MAX_AMT) ? STEP_W'(STEP_MAX) : rem_q[STEP_W-1:0];
      step_ext = AMT_W'(step);
   end

   shift u_shift (
      .a (data_q),
      .d (dir_q),
      .n (step),
      .x (shifted)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      dir_d   = dir_q;
      rem_d   = rem_q;
      case (state_q)
         ST_IDLE: begin
            // in_ready_q stays low for the first edge after reset release
            if (in_valid && in_ready_q) begin
               data_d  = in_data;
               dir_d   = in_dir;
               rem_d   = in_amt;
               state_d = (in_amt != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            data_d = shifted;
            rem_d  = rem_q - step_ext;
            if (rem_q == step_ext) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state so they are
   // all low during reset and line up exactly with state_q afterwards.
   always_comb begin
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         data_q      <= '0;
         dir_q       <= 1'b0;
         rem_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         dir_q       <= dir_d;
         rem_q       <= rem_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_data  = data_q;

endmodule
